dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// Data-side memory responder: the far end of the MEM-stage interface (address, store data, write strobe, byte enables).
// Holds a word-organised data RAM plus an MMIO window with a debug console TX FIFO, a 64-bit cycle counter and a TOHOST halt register.
// Read data is combinational, because the core samples it in the same cycle. Writes commit on the rising clock edge.
// PARAMETERS
// DEPTH_WORDS  1024           RAM size in 32-bit words; RAM window is 0x0 .. 4*DEPTH_WORDS-1
// MMIO_BASE    32'h1000_0000  base address of the 32-byte MMIO window
// FIFO_DEPTH   8              console FIFO entries (power of 2, >=2)
// INIT_FILE    ""             optional $readmemh image for the RAM; empty means no preload
// PORTS
// clk          in   1   clock, rising edge
// reset        in   1   asynchronous, active-high reset
// addr         in   32  byte address (core ALUResultM)
// wdata        in   32  store data, unaligned: data sits in the low byte/half as produced by the core
// we           in   1   write strobe (core MemWriteM)
// byte_enable  in   4   lane enables: one-hot = sb, 0011/1100 = sh, 1111 = sw
// rdata        out  32  aligned word at addr[31:2]; combinational
// tx_valid     out  1   console byte available
// tx_data      out  8   head-of-FIFO byte
// tx_ready     in   1   consumer accepts; a pop occurs when tx_valid & tx_ready
// halt         out  1   sticky; set by a TOHOST write
// exit_code    out  31  wdata[31:1] captured by the TOHOST write
// BEHAVIOUR
// Reset values: tx_valid=0, tx_data=0, halt=0, exit_code=0, cycle=0, FIFO count=0, overflow=0. RAM contents are not reset.
// Address decode: addr[1:0] is ignored. An address in neither window reads 0 and ignores writes.
// Store lane alignment is done here:
// - one-hot enable bit k: lane k <= wdata[7:0]
// - 0011: lanes 1:0 <= wdata[15:0]; 1100: lanes 3:2 <= wdata[15:0]
// - 1111: full word
// - any other pattern with we=1: no write
// MMIO offsets from MMIO_BASE:
// - 0x00 CONSOLE_TX, write-only: pushes wdata[7:0] when we & byte_enable[0]. Reads 0.
// - 0x04 STATUS, read: {20'b0, overflow, full, empty, 1'b0, count[7:0]}. Any write clears overflow.
// - 0x08 CYCLE_LO, 0x0C CYCLE_HI: read/write. A write with any byte_enable loads the full word, and that write takes precedence over the increment that cycle.
// - 0x10 TOHOST: a write with wdata[0]=1 sets halt and captures exit_code. Writes are ignored once halt=1.
// Cycle counter: +1 every cycle while halt=0, frozen once halt=1. The low-to-high carry occurs on the same edge. It wraps at 2^64.
// CYCLE reads are not atomic; software reads HI, LO, HI and retries on mismatch.
// FIFO behaviour:
// - Push to a full FIFO without a same-cycle pop: dropped, overflow set (sticky).
// - Push and pop together when full: both happen, count unchanged, no overflow.
// - Push and pop together when empty: impossible, since tx_valid=0 means no pop.
// - tx_data/tx_valid are registered state. A pushed byte is visible on tx_valid the cycle after the push (1-cycle latency).
// - tx_data holds its value while tx_valid & ~tx_ready.
// Reset mid-operation: FIFO, counter and halt return to reset values immediately (async). RAM is preserved.
// STRUCTURE
// dmem_pkg: MMIO offset localparams (OFF_TX, OFF_STATUS, OFF_CYC_LO, OFF_CYC_HI, OFF_TOHOST) and the status-field bit positions.
// Sub-module console_fifo (clk, reset, push, push_data, pop, head, count, full, empty) holds FIFO_DEPTH entries.
// The top level holds the RAM, the lane-alignment logic, the decode, the counter and TOHOST.
// TESTING
// 1. sw 0xDEADBEEF @0x40; sb wdata=0x55 en=0010 @0x41 -> read @0x40 = 0xDEAD55EF.
// 2. sh wdata=0x1234 en=1100 @0x42 after (1) -> read @0x40 = 0x123455EF; we=1 en=0101 -> word unchanged.
// 3. tx_ready=0: push 9 bytes 0x41..0x49 -> STATUS count=8, full=1, overflow=1; release tx_ready -> bytes 0x41..0x48 drained in order, empty=1.
// 4. FIFO full, push 0x5A and tx_ready=1 in the same cycle -> count stays 8, overflow stays 0, 0x5A is emitted last.
// 5. Write CYCLE_HI=0, CYCLE_LO=0xFFFF_FFFF -> two cycles later CYCLE_HI=1, CYCLE_LO=0x0000_0001.
// 6. TOHOST write 0x0000_0007 -> halt=1, exit_code=3, cycle frozen. Then assert reset with 3 bytes queued -> tx_valid=0, halt=0, count=0, RAM @0x40 intact.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and store lane-alignment helper for the data-memory responder.
package dmem_pkg;

  // MMIO register offsets from the window base
  localparam logic [4:0] OFF_TX     = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h04;
  localparam logic [4:0] OFF_CYC_LO = 5'h08;
  localparam logic [4:0] OFF_CYC_HI = 5'h0C;
  localparam logic [4:0] OFF_TOHOST = 5'h10;

  // STATUS register field positions; count occupies bits 7:0
  localparam int STAT_OVERFLOW = 11;
  localparam int STAT_FULL     = 10;
  localparam int STAT_EMPTY    = 9;

  typedef struct packed {
    logic        valid;
    logic [3:0]  mask;
    logic [31:0] data;
  } laneWrite_t;

  // The core leaves store data in the low byte/half, so replicate it across
  // the word; the enable mask then selects the lanes that really get written.
  function automatic laneWrite_t alignStore(input logic [3:0] byteEn, input logic [31:0] data);
    laneWrite_t lw;
    lw.valid = 1'b1;
    lw.mask  = byteEn;
    lw.data  = data;
    case (byteEn)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: lw.data = {4{data[7:0]}};
      4'b0011, 4'b1100:                   lw.data = {2{data[15:0]}};
      4'b1111:                            lw.data = data;
      default: begin
        lw.valid = 1'b0;
        lw.mask  = 4'b0000;
      end
    endcase
    return lw;
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Byte FIFO feeding the debug console. Head and flags come straight from
// registered state, so a pushed byte shows up the cycle after the push.
module console_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [7:0]                   push_data,
  input  logic                         pop,
  output logic [7:0]                   head,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       store [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic             doPop;
  logic             doPush;

  // A push into a full FIFO only lands if the same cycle frees a slot.
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);

  assign head  = store[rdPtr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= 8'h00;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        store[wrPtr] <= push_data;
        wrPtr        <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM plus MMIO window holding the console
// FIFO, a free-running 64-bit cycle counter and the TOHOST halt register.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [3:0]  byte_enable,
  output logic [31:0] rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt,
  output logic [30:0] exit_code
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      mem [DEPTH_WORDS];
  logic             ramHit;
  logic             mmioHit;
  logic [IDX_W-1:0] ramIdx;
  logic [4:0]       mmioOff;
  laneWrite_t       lane;
  logic             unusedAddrLsb;

  logic             wrTx, wrStatus, wrCycLo, wrCycHi, wrToHost;
  logic             pop;
  logic [CNT_W-1:0] fifoCount;
  logic             fifoFull, fifoEmpty;
  logic             overflow;
  logic [63:0]      cycle;
  logic [63:0]      cycleNext;
  logic [31:0]      statusWord;

  // Byte offset within the word is irrelevant: everything is word addressed.
  assign unusedAddrLsb = ^addr[1:0];
  assign ramHit  = ({2'b00, addr[31:2]} < 32'(DEPTH_WORDS));
  assign ramIdx  = addr[IDX_W+1:2];
  assign mmioHit = (addr[31:5] == MMIO_BASE[31:5]);
  assign mmioOff = {addr[4:2], 2'b00};
  assign lane    = alignStore(byte_enable, wdata);

  assign wrTx     = we & mmioHit & (mmioOff == OFF_TX) & byte_enable[0];
  assign wrStatus = we & mmioHit & (mmioOff == OFF_STATUS);
  assign wrCycLo  = we & mmioHit & (mmioOff == OFF_CYC_LO) & (|byte_enable);
  assign wrCycHi  = we & mmioHit & (mmioOff == OFF_CYC_HI) & (|byte_enable);
  assign wrToHost = we & mmioHit & (mmioOff == OFF_TOHOST) & wdata[0] & ~halt;

  assign tx_valid = ~fifoEmpty;
  assign pop      = tx_valid & tx_ready;

  console_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wrTx),
    .push_data (wdata[7:0]),
    .pop       (pop),
    .head      (tx_data),
    .count     (fifoCount),
    .full      (fifoFull),
    .empty     (fifoEmpty)
  );

  // Lane-masked RAM store; RAM is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (we && ramHit && lane.valid) begin
      for (int k = 0; k < 4; k++) begin
        if (lane.mask[k]) mem[ramIdx][8*k +: 8] <= lane.data[8*k +: 8];
      end
    end
  end

  // Sticky overflow: set by a dropped push, cleared by any STATUS write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            overflow <= 1'b0;
    else if (wrStatus)                    overflow <= 1'b0;
    else if (wrTx && fifoFull && !pop)    overflow <= 1'b1;
  end

  // Increment (with carry) first, then let a software write replace either half.
  always_comb begin
    cycleNext = halt ? cycle : cycle + 64'd1;
    if (wrCycLo) cycleNext[31:0]  = wdata;
    if (wrCycHi) cycleNext[63:32] = wdata;
  end

  // Cycle counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle <= 64'd0;
    else       cycle <= cycleNext;
  end

  // TOHOST latch: first write with bit 0 set halts and records the exit code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt      <= 1'b0;
      exit_code <= 31'd0;
    end else if (wrToHost) begin
      halt      <= 1'b1;
      exit_code <= wdata[31:1];
    end
  end

  // STATUS word assembly.
  always_comb begin
    statusWord                = 32'd0;
    statusWord[7:0]           = 8'(fifoCount);
    statusWord[STAT_EMPTY]    = fifoEmpty;
    statusWord[STAT_FULL]     = fifoFull;
    statusWord[STAT_OVERFLOW] = overflow;
  end

  // Combinational read mux; unmapped addresses and CONSOLE_TX read as zero.
  always_comb begin
    rdata = 32'd0;
    if (ramHit) begin
      rdata = mem[ramIdx];
    end else if (mmioHit) begin
      case (mmioOff)
        OFF_STATUS: rdata = statusWord;
        OFF_CYC_LO: rdata = cycle[31:0];
        OFF_CYC_HI: rdata = cycle[63:32];
        OFF_TOHOST: rdata = {exit_code, halt};
        default:    rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: RAM vector table, randomized RAM and
// FIFO traffic against reference models, and directed MMIO corner sequences.
module tb_dmem_responder;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] A_TX   = BASE + 32'h00;
  localparam logic [31:0] A_STAT = BASE + 32'h04;
  localparam logic [31:0] A_LO   = BASE + 32'h08;
  localparam logic [31:0] A_HI   = BASE + 32'h0C;
  localparam logic [31:0] A_HOST = BASE + 32'h10;
  localparam logic [31:0] RBASE  = 32'h100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [3:0]  byte_enable = '0;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        halt;
  logic [30:0] exit_code;

  int nVec = 0;
  int nErr = 0;

  dmem_responder dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .wdata       (wdata),
    .we          (we),
    .byte_enable (byte_enable),
    .rdata       (rdata),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .halt        (halt),
    .exit_code   (exit_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdAddr;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] ramModel [64];
  logic [7:0]  q[$];
  logic        ovfModel;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr = a; wdata = d; byte_enable = be; we = 1'b1;
    tick();
    we = 1'b0; byte_enable = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; we = 1'b0;
    #1;
    d = rdata;
  endtask

  // Reference store: apply the enable-pattern rules byte by byte.
  function automatic logic [31:0] modelStore(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] be);
    logic [31:0] w;
    w = old;
    case (be)
      4'b0001: w[7:0]   = d[7:0];
      4'b0010: w[15:8]  = d[7:0];
      4'b0100: w[23:16] = d[7:0];
      4'b1000: w[31:24] = d[7:0];
      4'b0011: w[15:0]  = d[15:0];
      4'b1100: w[31:16] = d[15:0];
      4'b1111: w        = d;
      default: w        = old;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] modelStatus();
    logic [31:0] s;
    s = 32'd0;
    s[7:0] = 8'(q.size());
    s[9]   = (q.size() == 0);
    s[10]  = (q.size() == 8);
    s[11]  = ovfModel;
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d, v1, v2;
    logic [3:0]  beList [12];
    logic [7:0]  exp4 [8];

    beList = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100,
               4'b1111, 4'b0101, 4'b0000, 4'b0110, 4'b1001, 4'b0111};

    // ---------------- reset state ----------------
    tick(); tick();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_halt", halt, 0);
    check("rst_exit_code", exit_code, 0);
    rd(A_STAT, d); check("rst_status", d, 32'h200);
    rd(A_LO, d);   check("rst_cycle_lo", d, 0);
    reset = 1'b0;
    tick();

    // ---------------- RAM vector table ----------------
    vecs.push_back('{1'b1, 32'h40,   32'hDEADBEEF, 4'b1111, 32'h40,  32'hDEADBEEF});
    vecs.push_back('{1'b1, 32'h41,   32'h00000055, 4'b0010, 32'h40,  32'hDEAD55EF});
    vecs.push_back('{1'b1, 32'h42,   32'h00001234, 4'b1100, 32'h40,  32'h123455EF});
    vecs.push_back('{1'b1, 32'h40,   32'hFFFFFFFF, 4'b0101, 32'h40,  32'h123455EF});
    vecs.push_back('{1'b1, 32'h44,   32'hCAFEF00D, 4'b1111, 32'h47,  32'hCAFEF00D});
    vecs.push_back('{1'b1, 32'h44,   32'h000000A5, 4'b1000, 32'h44,  32'hA5FEF00D});
    vecs.push_back('{1'b1, 32'h46,   32'h0000BEEF, 4'b0011, 32'h44,  32'hA5FEBEEF});
    vecs.push_back('{1'b0, 32'h44,   32'h00000000, 4'b1111, 32'h44,  32'hA5FEBEEF});
    vecs.push_back('{1'b1, 32'hFFC,  32'h11223344, 4'b1111, 32'hFFC, 32'h11223344});
    vecs.push_back('{1'b1, 32'h0,    32'h0BADF00D, 4'b1111, 32'h0,   32'h0BADF00D});
    vecs.push_back('{1'b1, 32'h1000, 32'h00000099, 4'b1111, 32'h1000, 32'h0});
    vecs.push_back('{1'b0, 32'h0,    32'h0,        4'b0000, 32'h0,   32'h0BADF00D});
    vecs.push_back('{1'b1, 32'h40,   32'h00000077, 4'b0001, 32'h40,  32'h12345577});
    vecs.push_back('{1'b0, 32'h0,    32'h0,        4'b0000, A_TX,    32'h0});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata, vecs[i].be);
      rd(vecs[i].rdAddr, d);
      check($sformatf("vec%0d", i), d, vecs[i].exp);
    end

    // ---------------- randomized RAM traffic ----------------
    for (int i = 0; i < 64; i++) begin
      ramModel[i] = 32'hA5A5A5A5 ^ (i * 32'h01010101);
      wr(RBASE + 32'(i * 4), ramModel[i], 4'b1111);
    end
    for (int i = 0; i < 300; i++) begin
      int          idx;
      logic [31:0] a, wd;
      logic [3:0]  be;
      idx = $urandom_range(0, 63);
      a   = RBASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
      wd  = $urandom;
      be  = beList[$urandom_range(0, 11)];
      case ($urandom_range(0, 7))
        0: begin
          // outside both windows: 0x1100 would alias word 0x100 if decode were partial
          a = ($urandom_range(0, 1) == 0) ? (32'h1100 + 32'(idx * 4)) : 32'h2000_0000;
          wr(a, wd, be);
          rd(a, d); check("rnd_unmapped", d, 0);
        end
        1, 2: begin
          rd(a, d); check("rnd_read", d, ramModel[idx]);
        end
        default: begin
          wr(a, wd, be);
          ramModel[idx] = modelStore(ramModel[idx], wd, be);
          rd(a, d); check("rnd_store", d, ramModel[idx]);
        end
      endcase
    end
    for (int i = 0; i < 64; i++) begin
      rd(RBASE + 32'(i * 4), d);
      check("rnd_final", d, ramModel[i]);
    end

    // ---------------- FIFO overflow and drain ----------------
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(A_TX, 32'h41 + 32'(i), 4'b0001);
    rd(A_STAT, d); check("ovf_status", d, 32'hC08);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", tx_valid, 1);
      check("drain_data", tx_data, 8'h41 + 8'(i));
      tick();
    end
    check("drain_empty_valid", tx_valid, 0);
    rd(A_STAT, d); check("drain_status", d, 32'hA00);
    wr(A_STAT, 32'h0, 4'b0001);
    rd(A_STAT, d); check("ovf_clear", d, 32'h200);

    // ---------------- push and pop together while full ----------------
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h61 + 32'(i), 4'b1111);
    rd(A_STAT, d); check("full_status", d, 32'h408);
    tx_ready = 1'b1;
    wr(A_TX, 32'h5A, 4'b0001);
    tx_ready = 1'b0;
    rd(A_STAT, d); check("pushpop_status", d, 32'h408);
    exp4 = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h5A};
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("pushpop_data", {tx_valid, tx_data}, {1'b1, exp4[i]});
      tick();
    end
    tx_ready = 1'b0;
    rd(A_STAT, d); check("pushpop_empty", d, 32'h200);

    // ---------------- randomized FIFO traffic ----------------
    ovfModel = 1'b0;
    q.delete();
    for (int i = 0; i < 240; i++) begin
      logic push, rdy, popped;
      logic [3:0] be;
      logic [31:0] wd;
      rd(A_STAT, d); check("rfifo_status", d, modelStatus());
      check("rfifo_valid", tx_valid, q.size() != 0);
      if (q.size() != 0) check("rfifo_data", tx_data, q[0]);
      push = (i < 120) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rdy  = (i < 120) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      be   = ($urandom_range(0, 4) == 0) ? 4'b1110 : 4'b0001;
      wd   = $urandom;
      tx_ready = rdy;
      addr = A_TX; wdata = wd; byte_enable = be; we = push;
      tick();
      we = 1'b0;
      popped = rdy && (q.size() != 0);
      if (popped) void'(q.pop_front());
      if (push && be[0]) begin
        if (q.size() < 8) q.push_back(wd[7:0]);
        else ovfModel = 1'b1;
      end
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    tx_ready = 1'b0;
    wr(A_STAT, 32'h0, 4'b1111);
    rd(A_STAT, d); check("rfifo_final", d, 32'h200);

    // ---------------- cycle counter ----------------
    rd(A_LO, v1);
    for (int i = 0; i < 5; i++) tick();
    rd(A_LO, v2); check("cycle_run", v2, v1 + 32'd5);
    wr(A_HI, 32'h0, 4'b1111);
    wr(A_LO, 32'hFFFF_FFFF, 4'b0100);
    rd(A_LO, d); check("cycle_lo_load", d, 32'hFFFF_FFFF);
    rd(A_HI, d); check("cycle_hi_load", d, 0);
    tick(); tick();
    rd(A_HI, d); check("cycle_carry_hi", d, 1);
    rd(A_LO, d); check("cycle_carry_lo", d, 1);
    wr(A_HI, 32'hFFFF_FFFF, 4'b1111);
    wr(A_LO, 32'hFFFF_FFFF, 4'b1111);
    tick();
    rd(A_HI, d); check("cycle_wrap_hi", d, 0);
    rd(A_LO, d); check("cycle_wrap_lo", d, 0);

    // ---------------- TOHOST, then async reset mid-operation ----------------
    for (int i = 0; i < 3; i++) wr(A_TX, 32'h31 + 32'(i), 4'b0001);
    wr(A_HOST, 32'h0000_0006, 4'b1111);
    check("host_bit0_clear", halt, 0);
    wr(A_HOST, 32'h0000_0007, 4'b1111);
    check("host_halt", halt, 1);
    check("host_exit", exit_code, 3);
    rd(A_LO, v1);
    for (int i = 0; i < 3; i++) tick();
    rd(A_LO, v2); check("host_frozen", v2, v1);
    wr(A_HOST, 32'h0000_0009, 4'b1111);
    check("host_sticky_exit", exit_code, 3);
    rd(A_STAT, d); check("host_queued", d, 32'h003);
    #2;
    reset = 1'b1;
    #1;
    check("arst_tx_valid", tx_valid, 0);
    check("arst_halt", halt, 0);
    check("arst_exit", exit_code, 0);
    rd(A_STAT, d); check("arst_status", d, 32'h200);
    rd(A_LO, d);   check("arst_cycle", d, 0);
    rd(32'h40, d); check("arst_ram", d, 32'h12345577);
    reset = 1'b0;
    tick();
    rd(A_LO, d);   check("post_rst_cycle", d, 1);
    rd(RBASE, d);  check("post_rst_ram", d, ramModel[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
